// File: rtl/uut_feed_pkg.sv
// Shared types and default sizing for the UUT feed buffer.
package uut_feed_pkg;

    typedef enum logic [1:0] {
        STREAM = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } feed_state_t;

    localparam int unsigned FEED_WORD_SIZE = 32;
    localparam int unsigned FEED_DEPTH     = 8;
    localparam int unsigned FEED_AF_MARGIN = 2;
    localparam int unsigned FEED_PTR_W     = $clog2(FEED_DEPTH);
    localparam int unsigned FEED_LVL_W     = FEED_PTR_W + 1;

endpackage

// File: rtl/feed_fifo.sv
// Circular FIFO with level counter; head word is kept in a register so the read port is registered.
module feed_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_nx_c,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nx;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic             do_push;
    logic             do_pop;

    // Clear wins over everything; a push into a full FIFO needs a same-cycle pop.
    always_comb begin
        full_c     = (level == LVL_W'(DEPTH));
        empty_c    = (level == '0);
        do_pop     = pop && !empty_c && !clear;
        do_push    = push && (!full_c || do_pop) && !clear;
        wr_ptr_nx  = wr_ptr;
        rd_ptr_nx  = rd_ptr;
        level_nx_c = level;
        if (clear) begin
            wr_ptr_nx  = '0;
            rd_ptr_nx  = '0;
            level_nx_c = '0;
        end else begin
            if (do_push) wr_ptr_nx = wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr_nx = rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      level_nx_c = level + LVL_W'(1);
            else if (do_pop && !do_push) level_nx_c = level - LVL_W'(1);
        end
    end

    // Head register bypasses the write only when the new word becomes the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            level  <= level_nx_c;
            rdata  <= (do_push && (wr_ptr == rd_ptr_nx)) ? wdata : mem[rd_ptr_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uut_feed_buffer.sv
// Elastic buffer from the core feed port to the UUT stream: FSM, backpressure and status flags.
module uut_feed_buffer
    import uut_feed_pkg::*;
#(
    parameter int unsigned WORD_SIZE = FEED_WORD_SIZE,
    parameter int unsigned DEPTH     = FEED_DEPTH,
    parameter int unsigned AF_MARGIN = FEED_AF_MARGIN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rst_uut,
    input  logic [WORD_SIZE-1:0]    feed_data_uut,
    input  logic                    feed_data_control_uut,
    input  logic                    stop_feed_uut,
    output logic                    busy_uut,
    output logic [WORD_SIZE-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    err_feed,
    output logic                    drained
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    feed_state_t      state;
    feed_state_t      state_nx;
    logic             push;
    logic             pop;
    logic             err_set;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level_nx;
    logic             busy_nx;
    logic             m_valid_nx;
    logic             m_last_nx;

    feed_fifo #(
        .W     (WORD_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (rst_uut),
        .push       (push),
        .pop        (pop),
        .wdata      (feed_data_uut),
        .rdata      (m_data),
        .level      (level),
        .level_nx_c (level_nx),
        .full_c     (full),
        .empty_c    (empty)
    );

    // Next state, accepted push and dropped-strobe detection; rst_uut overrides all.
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        err_set  = 1'b0;
        pop      = m_valid && m_ready;
        case (state)
            STREAM: begin
                if (feed_data_control_uut) begin
                    if (!full || pop) push    = 1'b1;
                    else              err_set = 1'b1;
                end
                if (stop_feed_uut) state_nx = DRAIN;
            end
            DRAIN: begin
                err_set = feed_data_control_uut;
                if (empty || (pop && m_last)) state_nx = DONE;
            end
            DONE: begin
                err_set = feed_data_control_uut;
            end
            default: state_nx = STREAM;
        endcase
        if (rst_uut) begin
            state_nx = STREAM;
            push     = 1'b0;
            err_set  = 1'b0;
        end
        busy_nx    = rst_uut || (state_nx != STREAM) || (level_nx >= LVL_W'(DEPTH - AF_MARGIN));
        m_valid_nx = !rst_uut && (level_nx != '0) && (state_nx != DONE);
        m_last_nx  = m_valid_nx && (state_nx == DRAIN) && (level_nx == LVL_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= STREAM;
            busy_uut <= 1'b1;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            err_feed <= 1'b0;
            drained  <= 1'b0;
        end else begin
            state    <= state_nx;
            busy_uut <= busy_nx;
            m_valid  <= m_valid_nx;
            m_last   <= m_last_nx;
            err_feed <= rst_uut ? 1'b0 : (err_feed | err_set);
            drained  <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_uut_feed_buffer.sv
// Directed checks of uut_feed_buffer ordering, backpressure, overflow, drain and resets.
module tb_uut_feed_buffer;

    logic        clk;
    logic        rst;
    logic        rst_uut;
    logic [31:0] feed_data_uut;
    logic        feed_data_control_uut;
    logic        stop_feed_uut;
    logic        busy_uut;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [3:0]  level;
    logic        err_feed;
    logic        drained;

    int checks = 0;
    int errors = 0;

    uut_feed_buffer #(
        .WORD_SIZE (32),
        .DEPTH     (8),
        .AF_MARGIN (2)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rst_uut               (rst_uut),
        .feed_data_uut         (feed_data_uut),
        .feed_data_control_uut (feed_data_control_uut),
        .stop_feed_uut         (stop_feed_uut),
        .busy_uut              (busy_uut),
        .m_data                (m_data),
        .m_valid               (m_valid),
        .m_ready               (m_ready),
        .m_last                (m_last),
        .level                 (level),
        .err_feed              (err_feed),
        .drained               (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        feed_data_uut         = d;
        feed_data_control_uut = 1'b1;
        tick();
        feed_data_control_uut = 1'b0;
    endtask

    task automatic pulse_rst_uut();
        rst_uut = 1'b1;
        tick();
        rst_uut = 1'b0;
    endtask

    logic [31:0] exp_q [8];

    initial begin
        rst = 1'b0; rst_uut = 1'b0; feed_data_uut = '0;
        feed_data_control_uut = 1'b0; stop_feed_uut = 1'b0; m_ready = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy_uut), 32'd1);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_flags", {29'd0, m_last, err_feed, drained}, 32'd0);
        rst = 1'b1;
        tick();
        check("busy_after_rst", 32'(busy_uut), 32'd0);

        // In-order pass-through, one cycle latency.
        m_ready = 1'b1;
        strobe(32'hA1);
        check("a1_valid", 32'(m_valid), 32'd1);
        check("a1_data", m_data, 32'hA1);
        strobe(32'hA2);
        check("a2_data", m_data, 32'hA2);
        check("a2_level", 32'(level), 32'd1);
        strobe(32'hA3);
        check("a3_data", m_data, 32'hA3);
        tick();
        check("a_level0", 32'(level), 32'd0);
        check("a_valid0", 32'(m_valid), 32'd0);

        // Fill with m_ready low: busy after 6th push.
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            strobe(32'h100 + 32'(k));
            check("fill_busy", 32'(busy_uut), (k >= 5) ? 32'd1 : 32'd0);
        end
        check("fill_level6", 32'(level), 32'd6);
        strobe(32'h106);
        check("fill_level7", 32'(level), 32'd7);
        check("fill_err0", 32'(err_feed), 32'd0);
        tick();
        check("fill_hold7", 32'(level), 32'd7);

        // Overflow drop, then accepted push at full with a pop.
        strobe(32'h107);
        check("full_level", 32'(level), 32'd8);
        strobe(32'hFF);
        check("ovf_err", 32'(err_feed), 32'd1);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_head", m_data, 32'h100);
        m_ready = 1'b1;
        strobe(32'hEE);
        check("fullpop_level", 32'(level), 32'd8);
        for (int i = 0; i < 7; i++) exp_q[i] = 32'h101 + 32'(i);
        exp_q[7] = 32'hEE;
        for (int i = 0; i < 8; i++) begin
            check("drain_order", m_data, exp_q[i]);
            tick();
        end
        check("drain_level0", 32'(level), 32'd0);
        check("drain_valid0", 32'(m_valid), 32'd0);
        check("err_sticky", 32'(err_feed), 32'd1);

        // End of stream with final word on the stop cycle.
        pulse_rst_uut();
        check("clr_err", 32'(err_feed), 32'd0);
        m_ready = 1'b0;
        strobe(32'h10);
        strobe(32'h20);
        stop_feed_uut = 1'b1;
        strobe(32'h30);
        check("stop_level", 32'(level), 32'd3);
        check("stop_busy", 32'(busy_uut), 32'd1);
        check("stop_last0", 32'(m_last), 32'd0);
        m_ready = 1'b1;
        check("d_10", m_data, 32'h10);
        tick();
        check("d_20", m_data, 32'h20);
        check("d_20_last", 32'(m_last), 32'd0);
        tick();
        check("d_30", m_data, 32'h30);
        check("d_30_last", 32'(m_last), 32'd1);
        check("d_30_drained", 32'(drained), 32'd0);
        tick();
        check("done_drained", 32'(drained), 32'd1);
        check("done_valid", 32'(m_valid), 32'd0);
        check("done_last", 32'(m_last), 32'd0);
        check("done_err0", 32'(err_feed), 32'd0);
        strobe(32'h55);
        check("done_err", 32'(err_feed), 32'd1);

        // Stop on an empty buffer.
        stop_feed_uut = 1'b0;
        pulse_rst_uut();
        check("clr_drained", 32'(drained), 32'd0);
        stop_feed_uut = 1'b1;
        tick();
        check("empty_stop_drained0", 32'(drained), 32'd0);
        check("empty_stop_last0", 32'(m_last), 32'd0);
        tick();
        check("empty_stop_drained", 32'(drained), 32'd1);
        check("empty_stop_last", 32'(m_last), 32'd0);
        stop_feed_uut = 1'b0;

        // rst_uut mid-stream with an ignored strobe.
        pulse_rst_uut();
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) strobe(32'h200 + 32'(k));
        check("mid_level5", 32'(level), 32'd5);
        feed_data_uut = 32'h2FF;
        feed_data_control_uut = 1'b1;
        pulse_rst_uut();
        feed_data_control_uut = 1'b0;
        check("ru_level", 32'(level), 32'd0);
        check("ru_valid", 32'(m_valid), 32'd0);
        check("ru_err", 32'(err_feed), 32'd0);

        // Asynchronous rst in the middle of DRAIN.
        strobe(32'h301);
        strobe(32'h302);
        stop_feed_uut = 1'b1;
        tick();
        stop_feed_uut = 1'b0;
        strobe(32'h303);
        check("drain_err", 32'(err_feed), 32'd1);
        check("drain_lvl2", 32'(level), 32'd2);
        #3 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy_uut), 32'd1);
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_flags", {29'd0, m_last, err_feed, drained}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("rel_busy", 32'(busy_uut), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
